// File: rtl/sc_levelctrl_pkg.sv
// rtl/sc_levelctrl_pkg.sv - shared game constants and level-controller state encoding
package sc_levelctrl_pkg;

  localparam int LEVEL_W          = 4;
  localparam int GOAL_ROW_DEF     = 0;
  localparam int MAX_LEVEL_DEF    = 9;
  localparam int PAUSE_TICKS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_PLAY    = 3'd0,
    ST_ARRIVE  = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_WIN     = 3'd4
  } state_t;

endpackage

// File: rtl/sc_pausetimer.sv
// rtl/sc_pausetimer.sv - loadable tick-driven down-counter for the post-level pause
module sc_pausetimer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [TMR_W-1:0] cnt;

  // Load wins over tick; the counter saturates at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = tick && (cnt == TMR_W'(1));

endmodule

// File: rtl/sc_levelctrl.sv
// rtl/sc_levelctrl.sv - goal detection, level-up pulse, timed pause and win latch
module sc_levelctrl
  import sc_levelctrl_pkg::*;
#(
  parameter int ROW_W       = 4,
  parameter int GOAL_ROW    = GOAL_ROW_DEF,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF,
  parameter int PAUSE_TICKS = PAUSE_TICKS_DEF,
  parameter int TMR_W       = 8
) (
  input  logic               SC_LEVELCTRL_CLOCK_50,
  input  logic               SC_LEVELCTRL_RESET_InLow,
  input  logic [ROW_W-1:0]   SC_LEVELCTRL_FROGROW_InBUS,
  input  logic               SC_LEVELCTRL_DEAD_InHigh,
  input  logic               SC_LEVELCTRL_TICK_InHigh,
  input  logic [LEVEL_W-1:0] SC_LEVELCTRL_LEVEL_InBUS,
  output logic               SC_LEVELCTRL_CUENTA_Out,
  output logic               SC_LEVELCTRL_FROGRESET_Out,
  output logic               SC_LEVELCTRL_PAUSE_Out,
  output logic               SC_LEVELCTRL_WIN_Out,
  output logic [2:0]         SC_LEVELCTRL_STATE_OutBUS
);

  state_t state;
  logic   on_goal_row;
  logic   goal;
  logic   last_level;
  logic   tmr_load;
  logic   tmr_tick;
  logic   tmr_done;

  assign on_goal_row = (SC_LEVELCTRL_FROGROW_InBUS == ROW_W'(GOAL_ROW));
  assign goal        = on_goal_row && !SC_LEVELCTRL_DEAD_InHigh;
  assign last_level  = (SC_LEVELCTRL_LEVEL_InBUS >= LEVEL_W'(MAX_LEVEL));
  assign tmr_load    = (state == ST_ARRIVE);
  assign tmr_tick    = SC_LEVELCTRL_TICK_InHigh && (state == ST_PAUSE);

  sc_pausetimer #(.TMR_W(TMR_W)) u_pausetimer (
    .clk      (SC_LEVELCTRL_CLOCK_50),
    .rst_n    (SC_LEVELCTRL_RESET_InLow),
    .load     (tmr_load),
    .load_val (TMR_W'(PAUSE_TICKS)),
    .tick     (tmr_tick),
    .done     (tmr_done)
  );

  // Outputs are written on the same edge as the state they belong to, so they are pure Moore.
  always_ff @(posedge SC_LEVELCTRL_CLOCK_50 or negedge SC_LEVELCTRL_RESET_InLow) begin
    if (!SC_LEVELCTRL_RESET_InLow) begin
      state                      <= ST_PLAY;
      SC_LEVELCTRL_CUENTA_Out    <= 1'b0;
      SC_LEVELCTRL_FROGRESET_Out <= 1'b0;
      SC_LEVELCTRL_PAUSE_Out     <= 1'b0;
      SC_LEVELCTRL_WIN_Out       <= 1'b0;
    end else begin
      case (state)
        ST_PLAY: begin
          if (goal && last_level) begin
            state                  <= ST_WIN;
            SC_LEVELCTRL_PAUSE_Out <= 1'b1;
            SC_LEVELCTRL_WIN_Out   <= 1'b1;
          end else if (goal) begin
            state                      <= ST_ARRIVE;
            SC_LEVELCTRL_CUENTA_Out    <= 1'b1;
            SC_LEVELCTRL_PAUSE_Out     <= 1'b1;
            SC_LEVELCTRL_FROGRESET_Out <= 1'b1;
          end
        end
        ST_ARRIVE: begin
          state                   <= ST_PAUSE;
          SC_LEVELCTRL_CUENTA_Out <= 1'b0;
        end
        ST_PAUSE: begin
          if (tmr_done) begin
            state                  <= ST_RELEASE;
            SC_LEVELCTRL_PAUSE_Out <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // Holding here until the frog leaves the goal row prevents a second count.
          if (!on_goal_row) begin
            state                      <= ST_PLAY;
            SC_LEVELCTRL_FROGRESET_Out <= 1'b0;
          end
        end
        ST_WIN: begin
          state <= ST_WIN;
        end
        default: begin
          state                      <= ST_PLAY;
          SC_LEVELCTRL_CUENTA_Out    <= 1'b0;
          SC_LEVELCTRL_FROGRESET_Out <= 1'b0;
          SC_LEVELCTRL_PAUSE_Out     <= 1'b0;
          SC_LEVELCTRL_WIN_Out       <= 1'b0;
        end
      endcase
    end
  end

  assign SC_LEVELCTRL_STATE_OutBUS = state;

endmodule
